cursor_overlay: RTL



---
 rtl/cursor_overlay.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/cursor_overlay.sv
// rtl/cursor_overlay.sv - text-mode hardware cursor overlay on the VGA pixel stream, 2-clock latency
module cursor_overlay #(
    parameter int BPP        = 8,
    parameter int COLS       = 80,
    parameter int BLINK_LOG2 = 5
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           blank_n_i,
    input  logic           hs_i,
    input  logic           vs_i,
    input  logic [BPP-1:0] red_i,
    input  logic [BPP-1:0] green_i,
    input  logic [BPP-1:0] blue_i,
    input  logic [31:0]    cursorpos,
    input  logic [3:0]     cursormode,
    input  logic [23:0]    cursorcolor,
    output logic           blank_n,
    output logic           hs,
    output logic           vs,
    output logic [BPP-1:0] red,
    output logic [BPP-1:0] green,
    output logic [BPP-1:0] blue
);

    localparam int            CW      = $clog2(COLS + 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS);

    logic                  vs_d;
    logic                  blank_d;
    logic                  vs_rise;
    logic                  blank_fall;
    logic [15:0]           line;
    logic [3:0]            scan;
    logic [3:0]            sub;
    logic [CW-1:0]         col;
    logic [BLINK_LOG2:0]   blink_cnt;
    logic [31:0]           sh_pos;
    logic [3:0]            sh_mode;
    logic [23:0]           sh_color;
    logic                  shape_ok;
    logic                  blink_ok;
    logic                  hit;
    logic                  s1_blank;
    logic                  s1_hs;
    logic                  s1_vs;
    logic                  s1_hit;
    logic [3*BPP-1:0]      s1_pix;
    logic [3*BPP-1:0]      pix_out;

    assign vs_rise    = vs_i & ~vs_d;
    assign blank_fall = blank_d & ~blank_n_i;
    assign scan       = line[3:0];

    // Frame-rate state: a vs rising edge clears the line count even if a line ends on the same clock.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs_d      <= 1'b0;
            blank_d   <= 1'b0;
            line      <= 16'd0;
            blink_cnt <= '0;
            sh_pos    <= 32'd0;
            sh_mode   <= 4'd0;
            sh_color  <= 24'd0;
        end else begin
            vs_d    <= vs_i;
            blank_d <= blank_n_i;
            if (vs_rise) begin
                line      <= 16'd0;
                blink_cnt <= blink_cnt + 1'b1;
                sh_pos    <= cursorpos;
                sh_mode   <= cursormode;
                sh_color  <= cursorcolor;
            end else if (blank_fall && line != 16'hFFFF) begin
                line <= line + 16'd1;
            end
        end
    end

    // Nine dots per cell: sub 0..7 glyph, sub 8 gap; col sticks at COLS past the text area.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sub <= 4'd0;
            col <= '0;
        end else if (!blank_n_i) begin
            sub <= 4'd0;
            col <= '0;
        end else if (sub == 4'd8) begin
            sub <= 4'd0;
            if (col != COL_MAX) begin
                col <= col + 1'b1;
            end
        end else begin
            sub <= sub + 4'd1;
        end
    end

    always_comb begin
        shape_ok = sh_mode[2] ? (scan >= 4'd4) : (scan == 4'd15);
        blink_ok = ~sh_mode[1] | ~blink_cnt[BLINK_LOG2];
        hit      = sh_mode[0] & blank_n_i
                 & (16'(col) == sh_pos[15:0]) & (col < COL_MAX)
                 & ({4'd0, line[15:4]} == sh_pos[31:16])
                 & (sub <= 4'd7) & shape_ok & blink_ok;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_blank <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hit   <= 1'b0;
            s1_pix   <= '0;
        end else begin
            s1_blank <= blank_n_i;
            s1_hs    <= hs_i;
            s1_vs    <= vs_i;
            s1_hit   <= hit;
            s1_pix   <= {red_i, green_i, blue_i};
        end
    end

    always_comb begin
        pix_out = s1_pix;
        if (s1_hit) begin
            pix_out = sh_mode[3] ? ~s1_pix : sh_color;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blank_n <= 1'b0;
            hs      <= 1'b0;
            vs      <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else begin
            blank_n            <= s1_blank;
            hs                 <= s1_hs;
            vs                 <= s1_vs;
            {red, green, blue} <= pix_out;
        end
    end

endmodule
